ymux_rr_reg: RTL and testbench
==============================

Name: ymux_rr_reg

Overview:
Parametrised N-channel, WIDTH-bit registered multiplexer; successor to the combinational 4-to-1 mux family. Selects one input channel per cycle, either by explicit select (direct mode) or by a fair round-robin pointer (RR mode). Moves data through a one-entry output register with valid/ready handshakes on both sides. Sits between datapath sources (register file read ports, ALU results) and a single shared consumer.

Parameters:
WIDTH, 32, data width per channel in bits (>=1)
CHANNELS, 4, number of input channels (2..16, need not be a power of two)
SEL_W, derived localparam = max(1, clog2(CHANNELS)), width of select/channel fields

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
in_data  input  CHANNELS*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  CHANNELS  per-channel valid
in_ready  output  CHANNELS  per-channel ready (combinational, at most one bit high)
mode  input  1  0 = direct select, 1 = round-robin
sel  input  SEL_W  channel select in direct mode; ignored in RR mode
out_data  output  WIDTH  registered selected data
out_chan  output  SEL_W  channel index of the word held in out_data
out_valid  output  1  output register holds a word
out_ready  input  1  consumer accepts the word this cycle
sel_err  output  1  registered flag: direct-mode sel >= CHANNELS seen last cycle

Behaviour:
- Reset (async assert, sync-safe release): out_valid=0, out_data=0, out_chan=0, sel_err=0, RR pointer ptr=0. Asserting reset mid-transfer discards the held word; no in_ready is high while reset is asserted.
- load_en = !out_valid || out_ready (the output register is free or is being drained this cycle). Full-throughput: one word per cycle when the consumer holds out_ready=1.
- Grant selection (combinational, same cycle):
  - Direct mode: cand = sel. Grant if sel < CHANNELS and in_valid[sel]. If sel >= CHANNELS, no grant.
  - RR mode: cand = the first i with in_valid[i], scanning ptr, ptr+1, ... wrapping modulo CHANNELS (not modulo 2^SEL_W). No valid channel means no grant.
- in_ready[i] = load_en && grant && (i == cand). All other bits are 0. A channel transfers when in_valid[i] && in_ready[i].
- On a clock edge with load_en: if grant, out_data<=channel cand data, out_chan<=cand, out_valid<=1. If no grant, out_valid<=0 and out_data/out_chan hold their values.
- On a clock edge without load_en (out_valid=1, out_ready=0): out_data, out_chan and out_valid hold. Held data must be stable. No input is acked.
- Latency: an input accepted on edge k appears on out_data after edge k (1 cycle).
- ptr update: only on an RR-mode transfer, ptr <= (cand==CHANNELS-1) ? 0 : cand+1. Direct-mode transfers and idle cycles leave ptr unchanged.
- Mode switches take effect on the same cycle's selection. ptr is retained across mode switches.
- sel_err <= (mode==0 && sel>=CHANNELS) on every edge. It is independent of load_en and always 0 when CHANNELS is a power of two.
- Simultaneous drain and load: out_ready=1 while out_valid=1 and a grant exists produces back-to-back words with out_valid staying 1.

Test Plan:
- Reset: assert reset mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_chan=0, sel_err=0 immediately, without waiting for a clock edge. After release, the first RR grant goes to the lowest valid channel at or after 0.
- Direct mode, WIDTH=32, CHANNELS=4, out_ready=1: in_data channels = 0xA0A0A0A0, 0xA1A1A1A1, 0xA2A2A2A2, 0xA3A3A3A3, all valid, sel=2 -> in_ready=4'b0100, next cycle out_data=0xA2A2A2A2, out_chan=2. Repeat with 10 random sel/data: out_data must equal the selected channel every cycle.
- RR fairness: all 4 channels valid continuously, mode=1, out_ready=1 -> out_chan sequence 0,1,2,3,0,1... With only channels 1 and 3 valid -> 1,3,1,3.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0, out_data/out_chan stable. Then out_ready=1 -> the held word drains and the next word loads on the same edge.
- Non-power-of-two: CHANNELS=3, RR mode, all valid -> 0,1,2,0 (no index 3 ever). Direct mode with sel=3 -> no in_ready, out_valid drops, sel_err=1 next cycle.
- Mode switch: in RR mode, grant channel 1 (ptr=2). Switch to direct with sel=0 for 2 transfers, then back to RR with all valid -> the next RR grant is channel 2.

Source files
------------

// File: rtl/ymux_rr_reg_if.sv
// Handshake bundle between the channel sources, the registered mux and its single consumer.
interface ymux_rr_reg_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4
);
    localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;
    logic                      sel_err;

    // Source/consumer side: drives channel data, select and consumer ready.
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid, sel_err
    );

    // Mux side.
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid, sel_err
    );
endinterface

// File: rtl/ymux_rr_reg.sv
// N-channel registered multiplexer with direct or round-robin selection and a
// one-entry output register behind valid/ready handshakes.
module ymux_rr_reg #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4
) (
    input  logic         clk,
    input  logic         reset,
    ymux_rr_reg_if.slave bus
);
    localparam int unsigned     SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [SEL_W:0]  CH_CNT = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(CHANNELS - 1);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_chan;
    logic             r_out_valid;
    logic             r_sel_err;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load_en;
    logic             w_sel_ok;
    logic             w_dir_valid;
    logic             w_rr_found;
    logic [SEL_W-1:0] w_rr_cand;
    logic [SEL_W:0]   w_rr_idx;
    logic             w_grant;
    logic [SEL_W-1:0] w_cand;
    logic [WIDTH-1:0] w_cand_data;

    assign w_load_en = !r_out_valid || bus.out_ready;
    assign w_sel_ok  = {1'b0, bus.sel} < CH_CNT;

    // Direct mode: valid of the selected channel; out-of-range selects never match.
    always_comb begin
        w_dir_valid = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (bus.sel == SEL_W'(i)) w_dir_valid = bus.in_valid[i];
        end
    end

    // Round-robin: first valid channel scanning from ptr, wrapping at CHANNELS.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_cand  = '0;
        w_rr_idx   = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            w_rr_idx = {1'b0, r_ptr} + (SEL_W+1)'(k);
            if (w_rr_idx >= CH_CNT) w_rr_idx = w_rr_idx - CH_CNT;
            if (!w_rr_found && bus.in_valid[w_rr_idx[SEL_W-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_cand  = w_rr_idx[SEL_W-1:0];
            end
        end
    end

    // Grant, candidate data mux and per-channel ready (held low during reset).
    always_comb begin
        w_cand       = bus.mode ? w_rr_cand  : bus.sel;
        w_grant      = bus.mode ? w_rr_found : w_dir_valid;
        w_cand_data  = '0;
        bus.in_ready = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (w_cand == SEL_W'(i)) begin
                w_cand_data     = bus.in_data[i*WIDTH +: WIDTH];
                bus.in_ready[i] = !reset && w_load_en && w_grant;
            end
        end
    end

    // Output register, select-error flag and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_sel_err   <= 1'b0;
            r_ptr       <= '0;
        end else begin
            r_sel_err <= !bus.mode && !w_sel_ok;
            if (w_load_en) begin
                if (w_grant) begin
                    r_out_data  <= w_cand_data;
                    r_out_chan  <= w_cand;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
            if (w_load_en && w_grant && bus.mode) begin
                r_ptr <= (w_cand == LAST) ? '0 : w_cand + SEL_W'(1);
            end
        end
    end

    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;
    assign bus.out_valid = r_out_valid;
    assign bus.sel_err   = r_sel_err;
endmodule

// File: tb/tb_ymux_rr_reg.sv
// Bench for ymux_rr_reg: a 4x32 and a 3x8 instance, each tracked by a
// transaction-level model of the grant rules and the output register.
module tb_ymux_rr_reg;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ymux_rr_reg_if #(.WIDTH(32), .CHANNELS(4)) bus4 ();
    ymux_rr_reg_if #(.WIDTH(8),  .CHANNELS(3)) bus3 ();

    ymux_rr_reg #(.WIDTH(32), .CHANNELS(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
    ymux_rr_reg #(.WIDTH(8),  .CHANNELS(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus per instance (index 0 = 4 channels, 1 = 3 channels).
    logic [31:0] s_data  [2][4];
    logic [3:0]  s_valid [2];
    logic        s_mode  [2];
    logic [1:0]  s_sel   [2];
    logic        s_ordy  [2];

    // Model state.
    logic        m_valid [2];
    logic [31:0] m_data  [2];
    int          m_chan  [2];
    logic        m_err   [2];
    int          m_ptr   [2];
    logic [3:0]  last_rdy[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int nch(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic logic [31:0] dmask(input int d);
        return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic logic [31:0] obs_data(input int d);
        return (d == 0) ? bus4.out_data : {24'h0, bus3.out_data};
    endfunction

    function automatic logic [31:0] obs_chan(input int d);
        return (d == 0) ? {30'h0, bus4.out_chan} : {30'h0, bus3.out_chan};
    endfunction

    function automatic logic [3:0] obs_rdy(input int d);
        return (d == 0) ? bus4.in_ready : {1'b0, bus3.in_ready};
    endfunction

    function automatic logic obs_valid(input int d);
        return (d == 0) ? bus4.out_valid : bus3.out_valid;
    endfunction

    function automatic logic obs_err(input int d);
        return (d == 0) ? bus4.sel_err : bus3.sel_err;
    endfunction

    task automatic apply();
        bus4.in_data   = {s_data[0][3], s_data[0][2], s_data[0][1], s_data[0][0]};
        bus4.in_valid  = s_valid[0];
        bus4.mode      = s_mode[0];
        bus4.sel       = s_sel[0];
        bus4.out_ready = s_ordy[0];
        bus3.in_data   = {s_data[1][2][7:0], s_data[1][1][7:0], s_data[1][0][7:0]};
        bus3.in_valid  = s_valid[1][2:0];
        bus3.mode      = s_mode[1];
        bus3.sel       = s_sel[1];
        bus3.out_ready = s_ordy[1];
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_chan[d]  = 0;
            m_err[d]   = 1'b0;
            m_ptr[d]   = 0;
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("out_valid%0d", d), 32'(obs_valid(d)), 32'(m_valid[d]));
            check($sformatf("out_data%0d", d),  obs_data(d), m_data[d]);
            check($sformatf("out_chan%0d", d),  obs_chan(d), 32'(m_chan[d]));
            check($sformatf("sel_err%0d", d),   32'(obs_err(d)), 32'(m_err[d]));
        end
    endtask

    // One clock cycle: drive at negedge, check ready, advance model at posedge, check outputs.
    task automatic step();
        logic        nv [2];
        logic [31:0] nd [2];
        int          nc [2];
        logic        ne [2];
        int          np [2];
        apply();
        #1;
        for (int d = 0; d < 2; d++) begin
            logic       load;
            logic       grant;
            int         cand;
            logic [3:0] exp_rdy;
            load  = !m_valid[d] || s_ordy[d];
            grant = 1'b0;
            cand  = 0;
            if (!s_mode[d]) begin
                cand  = int'(s_sel[d]);
                grant = (cand < nch(d)) && s_valid[d][cand];
            end else begin
                for (int k = 0; k < nch(d); k++) begin
                    int c;
                    c = (m_ptr[d] + k) % nch(d);
                    if (!grant && s_valid[d][c]) begin
                        grant = 1'b1;
                        cand  = c;
                    end
                end
            end
            exp_rdy = (load && grant) ? 4'(1 << cand) : 4'h0;
            last_rdy[d] = obs_rdy(d);
            check($sformatf("in_ready%0d", d), 32'(last_rdy[d]), 32'(exp_rdy));
            nv[d] = m_valid[d];
            nd[d] = m_data[d];
            nc[d] = m_chan[d];
            np[d] = m_ptr[d];
            ne[d] = !s_mode[d] && (int'(s_sel[d]) >= nch(d));
            if (load) begin
                if (grant) begin
                    nv[d] = 1'b1;
                    nd[d] = s_data[d][cand] & dmask(d);
                    nc[d] = cand;
                    if (s_mode[d]) np[d] = (cand + 1) % nch(d);
                end else begin
                    nv[d] = 1'b0;
                end
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = nv[d];
            m_data[d]  = nd[d];
            m_chan[d]  = nc[d];
            m_err[d]   = ne[d];
            m_ptr[d]   = np[d];
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_idle(input int d);
        s_valid[d] = '0;
        s_mode[d]  = 1'b0;
        s_sel[d]   = '0;
        s_ordy[d]  = 1'b1;
        for (int c = 0; c < 4; c++) s_data[d][c] = '0;
    endtask

    task automatic set_pattern0();
        s_data[0][0] = 32'hA0A0_A0A0;
        s_data[0][1] = 32'hA1A1_A1A1;
        s_data[0][2] = 32'hA2A2_A2A2;
        s_data[0][3] = 32'hA3A3_A3A3;
    endtask

    task automatic randomize_in(input int d);
        for (int c = 0; c < 4; c++) s_data[d][c] = $urandom;
        s_valid[d] = 4'($urandom);
        s_mode[d]  = 1'($urandom);
        s_sel[d]   = 2'($urandom);
        s_ordy[d]  = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int seq4[6];
        int seq13[4];
        int seq3[4];
        seq4  = '{0, 1, 2, 3, 0, 1};
        seq13 = '{3, 1, 3, 1};
        seq3  = '{0, 1, 2, 0};

        reset = 1'b1;
        set_idle(0);
        set_idle(1);
        apply();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        reset = 1'b0;

        // 3-channel instance: round-robin wraps at 3, then an out-of-range direct select.
        s_mode[1] = 1'b1; s_valid[1] = 4'b0111;
        for (int c = 0; c < 3; c++) s_data[1][c] = 32'h10 + 32'(c);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr3_chan", obs_chan(1), 32'(seq3[i]));
        end
        s_mode[1] = 1'b0; s_sel[1] = 2'd3;
        step();
        check("sel3_rdy", 32'(last_rdy[1]), 32'h0);
        check("sel3_valid", 32'(obs_valid(1)), 32'h0);
        check("sel3_err", 32'(obs_err(1)), 32'h1);
        set_idle(1);

        // Direct select of channel 2.
        set_pattern0();
        s_mode[0] = 1'b0; s_sel[0] = 2'd2; s_valid[0] = 4'hF; s_ordy[0] = 1'b1;
        step();
        check("dir_rdy", 32'(last_rdy[0]), 32'h4);
        check("dir_data", obs_data(0), 32'hA2A2_A2A2);
        check("dir_chan", obs_chan(0), 32'h2);

        // Round-robin with all channels valid, then only channels 1 and 3.
        s_mode[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rr4_chan", obs_chan(0), 32'(seq4[i]));
        end
        s_valid[0] = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rr13_chan", obs_chan(0), 32'(seq13[i]));
        end

        // Backpressure holds channel 1's word; release drains it and loads channel 2.
        s_valid[0] = 4'hF; s_ordy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_rdy", 32'(last_rdy[0]), 32'h0);
            check("bp_data", obs_data(0), 32'hA1A1_A1A1);
        end
        s_ordy[0] = 1'b1;
        step();
        check("bp_drain_rdy", 32'(last_rdy[0]), 32'h4);
        check("bp_drain_chan", obs_chan(0), 32'h2);

        // Mode switch keeps the round-robin pointer.
        s_valid[0] = 4'b0010;
        step();
        check("ms_rr1", obs_chan(0), 32'h1);
        s_mode[0] = 1'b0; s_sel[0] = 2'd0; s_valid[0] = 4'hF;
        step();
        step();
        check("ms_dir0", obs_chan(0), 32'h0);
        s_mode[0] = 1'b1;
        step();
        check("ms_rr2", obs_chan(0), 32'h2);

        // Asynchronous reset while a word is held.
        s_ordy[0] = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("rst_valid", 32'(bus4.out_valid), 32'h0);
        check("rst_data", bus4.out_data, 32'h0);
        check("rst_chan", 32'(bus4.out_chan), 32'h0);
        check("rst_err", 32'(bus4.sel_err), 32'h0);
        check("rst_rdy", 32'(bus4.in_ready), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        s_ordy[0] = 1'b1; s_valid[0] = 4'b0110;
        step();
        check("post_rst_chan", obs_chan(0), 32'h1);

        // Randomized traffic on both instances.
        for (int i = 0; i < 400; i++) begin
            randomize_in(0);
            randomize_in(1);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
